// File: rtl/reset_gen_pkg.sv
// Shared definitions for the reset generator: FSM state encoding and counter sizing.
`timescale 1ns/1ps
package reset_gen_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_HOLD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_SOFT   = 2'd3
  } state_e;

  // The counter reaches HOLD_CYCLES at the last HOLD increment, so it must hold that value.
  function automatic int cnt_width(input int hold_cycles);
    return $clog2(hold_cycles + 1);
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Deassertion synchronizer: cleared asynchronously, releases after STAGES clock edges.
`timescale 1ns/1ps
module reset_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic async_reset_n,
  output logic o_sync_n
);

  logic [STAGES-1:0] r_sync;

  // Shift ones in once the board reset is released; any low pulse clears the chain.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      r_sync <= {STAGES{1'b0}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], 1'b1};
    end
  end

  assign o_sync_n = r_sync[STAGES-1];

endmodule

// File: rtl/reset_gen.sv
// Reset generator: async assert, synchronized and stretched deassert, plus a
// clock-synchronous soft reset that only drives the synchronous reset output.
`timescale 1ns/1ps
module reset_gen
  import reset_gen_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16
) (
  input  logic clk,
  input  logic async_reset_n,
  input  logic i_soft_reset,
  output logic o_async_reset_n,
  output logic o_async_reset,
  output logic o_sync_reset,
  output logic o_reset_done
);

  localparam int             CW       = cnt_width(HOLD_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0]  CNT_ZERO = CW'(32'd0);

  state_e        r_state;
  state_e        w_next_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_next_cnt;
  logic          w_sync_n;
  logic          w_rst_n_next;
  logic          w_sync_rst_next;
  logic          w_done_next;

  reset_sync #(
    .STAGES (SYNC_STAGES)
  ) u_reset_sync (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .o_sync_n      (w_sync_n)
  );

  // Next-state, counter update and output decode from the next state.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      ST_ASSERT: begin
        if (w_sync_n) begin
          w_next_state = ST_HOLD;
          w_next_cnt   = CNT_ZERO;
        end else begin
          w_next_state = ST_ASSERT;
        end
      end
      ST_HOLD: begin
        w_next_cnt = r_cnt + CNT_ONE;
        if (r_cnt == CNT_LAST) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_HOLD;
        end
      end
      ST_RUN: begin
        if (i_soft_reset) begin
          w_next_state = ST_SOFT;
          w_next_cnt   = CNT_ZERO;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_SOFT: begin
        // Counter saturates so a long request simply extends the pulse.
        if (r_cnt == CNT_LAST) begin
          if (i_soft_reset) begin
            w_next_state = ST_SOFT;
          end else begin
            w_next_state = ST_RUN;
          end
        end else begin
          w_next_cnt   = r_cnt + CNT_ONE;
          w_next_state = ST_SOFT;
        end
      end
      default: begin
        w_next_state = ST_ASSERT;
        w_next_cnt   = CNT_ZERO;
      end
    endcase

    w_rst_n_next    = (w_next_state == ST_RUN) || (w_next_state == ST_SOFT);
    w_sync_rst_next = (w_next_state != ST_RUN);
    w_done_next     = (w_next_state == ST_RUN) &&
                      ((r_state == ST_HOLD) || (r_state == ST_SOFT));
  end

  // State, counter and registered outputs; board reset forces everything asserted.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      r_state         <= ST_ASSERT;
      r_cnt           <= CNT_ZERO;
      o_async_reset_n <= 1'b0;
      o_async_reset   <= 1'b1;
      o_sync_reset    <= 1'b1;
      o_reset_done    <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_cnt           <= w_next_cnt;
      o_async_reset_n <= w_rst_n_next;
      o_async_reset   <= ~w_rst_n_next;
      o_sync_reset    <= w_sync_rst_next;
      o_reset_done    <= w_done_next;
    end
  end

endmodule

// File: tb/tb_reset_gen.sv
// Scoreboard bench: stimulus queues expected output changes (cycle + value),
// a monitor pops one entry on every observed output change of either instance.
`timescale 1ns/1ps
module tb_reset_gen;

  typedef struct {
    int         cyc;
    logic [7:0] v;
  } exp_t;

  localparam logic [3:0] V_RST  = 4'b0110;
  localparam logic [3:0] V_RUN  = 4'b1000;
  localparam logic [3:0] V_SOFT = 4'b1010;
  localparam logic [3:0] V_DONE = 4'b1001;

  logic clk;
  logic rst_a, rst_b, soft_a, soft_b;
  logic a_n, a_a, a_s, a_d;
  logic b_n, b_a, b_s, b_d;
  logic [7:0] w_obs;
  logic [7:0] prev;
  bit   have_prev;
  int   cyc;
  int   checks;
  int   errors;
  int   ev_n;
  int   r;
  exp_t exp_q[$];

  reset_gen u_dut_a (
    .clk             (clk),
    .async_reset_n   (rst_a),
    .i_soft_reset    (soft_a),
    .o_async_reset_n (a_n),
    .o_async_reset   (a_a),
    .o_sync_reset    (a_s),
    .o_reset_done    (a_d)
  );

  reset_gen #(
    .SYNC_STAGES (3),
    .HOLD_CYCLES (1)
  ) u_dut_b (
    .clk             (clk),
    .async_reset_n   (rst_b),
    .i_soft_reset    (soft_b),
    .o_async_reset_n (b_n),
    .o_async_reset   (b_a),
    .o_sync_reset    (b_s),
    .o_reset_done    (b_d)
  );

  assign w_obs = {a_n, a_a, a_s, a_d, b_n, b_a, b_s, b_d};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [3:0] va, input logic [3:0] vb);
    exp_t e;
    e.cyc = c;
    e.v   = {va, vb};
    exp_q.push_back(e);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sample();
    exp_t e;
    if (!have_prev || (w_obs != prev)) begin
      checks++;
      ev_n++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: got %b at cyc %0d, expected no change", w_obs, cyc);
      end else begin
        e = exp_q.pop_front();
        if ((w_obs != e.v) || ((e.cyc >= 0) && (e.cyc != cyc))) begin
          errors++;
          $display("FAIL event%0d: got %b at cyc %0d, expected %b at cyc %0d",
                   ev_n, w_obs, cyc, e.v, e.cyc);
        end
      end
      prev      = w_obs;
      have_prev = 1'b1;
    end
  endtask

  always @(negedge clk) sample();

  // Catch asynchronous assertion without waiting for a clock edge.
  always @(negedge rst_a or negedge rst_b) begin
    #1;
    sample();
  end

  initial begin
    checks = 0; errors = 0; ev_n = 0; have_prev = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1; soft_a = 1'b0; soft_b = 1'b0;
    push(-1, V_RST, V_RST);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;

    // Power-on: release after 5 cycles, deassert at edge 19 with done pulse.
    wait_neg(5);
    r = cyc; rst_a = 1'b1;
    push(r + 19, V_DONE, V_RST);
    push(r + 20, V_RUN,  V_RST);
    wait_neg(25);

    // Single-cycle soft request: 16-cycle sync reset.
    r = cyc; soft_a = 1'b1;
    push(r + 1,  V_SOFT, V_RST);
    push(r + 17, V_DONE, V_RST);
    push(r + 18, V_RUN,  V_RST);
    wait_neg(1);
    soft_a = 1'b0;
    wait_neg(24);

    // 40-cycle soft request: falls one edge after release.
    r = cyc; soft_a = 1'b1;
    push(r + 1,  V_SOFT, V_RST);
    push(r + 41, V_DONE, V_RST);
    push(r + 42, V_RUN,  V_RST);
    wait_neg(40);
    soft_a = 1'b0;
    wait_neg(5);

    // Full reset, then a 2 ns glitch in HOLD at cnt=7 restarts the sequence.
    r = cyc;
    push(r, V_RST, V_RST);
    #2 rst_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    wait_neg(10);
    r = cyc;
    #2 rst_a = 1'b0;
    #2 rst_a = 1'b1;
    push(r + 19, V_DONE, V_RST);
    push(r + 20, V_RUN,  V_RST);
    wait_neg(25);

    // Board reset mid-SOFT; soft request held through HOLD is ignored, then
    // SOFT follows RUN immediately after the done pulse.
    r = cyc; soft_a = 1'b1;
    push(r + 1, V_SOFT, V_RST);
    push(r + 5, V_RST,  V_RST);
    wait_neg(5);
    #2 rst_a = 1'b0;
    @(negedge clk);
    r = cyc; rst_a = 1'b1;
    push(r + 19, V_DONE, V_RST);
    push(r + 20, V_SOFT, V_RST);
    push(r + 36, V_DONE, V_RST);
    push(r + 37, V_RUN,  V_RST);
    wait_neg(20);
    soft_a = 1'b0;
    wait_neg(25);

    // SYNC_STAGES=3, HOLD_CYCLES=1: deassert at edge 5, 1-cycle soft pulse.
    r = cyc; rst_b = 1'b1;
    push(r + 5, V_RUN, V_DONE);
    push(r + 6, V_RUN, V_RUN);
    wait_neg(10);
    r = cyc; soft_b = 1'b1;
    push(r + 1, V_RUN, V_SOFT);
    push(r + 2, V_RUN, V_DONE);
    push(r + 3, V_RUN, V_RUN);
    wait_neg(1);
    soft_b = 1'b0;
    wait_neg(10);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d pending, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
